// File: rtl/fp_divider.sv
// -----------------------------------------------------------------------------
// fp_divider
//   Multi-cycle IEEE-754 single-precision divider (quotient = a / b).
//   A restoring divider produces 25 quotient bits, one bit per cycle.
//   Rounding is truncation. Denormal operands are treated as zero.
//   NaN, infinity and zero operands are decided in PACK. Every operation
//   runs through the same path, so the latency is always the same:
//   29 cycles from the start edge to the done cycle.
//
//   Ports
//     clk        in   1   clock; all state changes on the rising edge
//     reset      in   1   synchronous, active-high reset
//     a          in  32   dividend, captured when an operation starts
//     b          in  32   divisor, captured when an operation starts
//     available  in   1   start request; only looked at in IDLE
//     quotient   out 32   registered result; held until the next completion
//     done       out  1   one-cycle pulse; quotient is valid in that cycle
//     busy       out  1   high in every state except IDLE
//     fsm_state  out  3   current FSM state encoding, for observation only
//
//   Handshake: when the block is in IDLE and available=1 at a rising edge,
//   that edge starts an operation and captures a/b. While busy=1, available
//   is ignored and requests are not queued. The result is presented with a
//   single done pulse. If available stays high, the next operation starts at
//   the first IDLE edge after DONE, which gives one operation per 30 cycles.
// -----------------------------------------------------------------------------
module fp_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        available,
   output logic [31:0] quotient,
   output logic        done,
   output logic        busy,
   output logic [2:0]  fsm_state
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      UNPACK    = 3'd1,
      DIVIDE    = 3'd2,
      NORMALIZE = 3'd3,
      PACK      = 3'd4,
      DONE      = 3'd5
   } state_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   state_t             state;

   // Operands captured at the start edge
   logic [31:0]        op_a;
   logic [31:0]        op_b;

   // Unpacked fields
   logic               sign;
   logic [7:0]         ea;
   logic [7:0]         eb;
   logic [23:0]        mb;

   // Divider datapath
   logic [25:0]        rem;
   logic [24:0]        q;
   logic [4:0]         iter;

   // Normalized result before range and special-case checks
   logic signed [9:0]  exp_r;
   logic [22:0]        man_r;

   // Combinational helpers
   logic               qbit;
   logic [25:0]        rem_sub;
   logic signed [9:0]  exp_calc;
   logic [22:0]        man_calc;
   logic [31:0]        pack_result;

   logic a_zero, a_inf, a_nan;
   logic b_zero, b_inf, b_nan;

   assign fsm_state = state;

   // One restoring step: subtract the divisor when it fits.
   always_comb begin
      qbit    = (rem >= {2'b00, mb});
      rem_sub = qbit ? (rem - {2'b00, mb}) : rem;
   end

   // q[24] set means the mantissa ratio is >= 1.0, so the leading one is at
   // bit 24 and the exponent bias stays 127. Otherwise the leading one is
   // at bit 23 and the exponent is one lower.
   always_comb begin
      if (q[24]) begin
         man_calc = q[23:1];
         exp_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
      end else begin
         man_calc = q[22:0];
         exp_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
      end
   end

   // Operand classes come from the captured operands. An exponent of 0 is
   // zero whatever the mantissa, so denormals are flushed.
   always_comb begin
      a_zero = (op_a[30:23] == 8'h00);
      a_inf  = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'h0);
      a_nan  = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'h0);
      b_zero = (op_b[30:23] == 8'h00);
      b_inf  = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'h0);
      b_nan  = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'h0);
   end

   // Final result. The special cases are checked in priority order, so they
   // override the arithmetic result.
   always_comb begin
      pack_result = {sign, exp_r[7:0], man_r};
      if (exp_r >= 10'sd255) begin
         pack_result = {sign, 8'hFF, 23'h0};
      end else if (exp_r <= 10'sd0) begin
         pack_result = {sign, 31'h0};
      end
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         pack_result = QNAN;
      end else if (a_inf || b_zero) begin
         pack_result = {sign, 8'hFF, 23'h0};
      end else if (a_zero || b_inf) begin
         pack_result = {sign, 31'h0};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         quotient <= 32'h0;
         done     <= 1'b0;
         busy     <= 1'b0;
         op_a     <= 32'h0;
         op_b     <= 32'h0;
         sign     <= 1'b0;
         ea       <= 8'h0;
         eb       <= 8'h0;
         mb       <= 24'h0;
         rem      <= 26'h0;
         q        <= 25'h0;
         iter     <= 5'h0;
         exp_r    <= 10'sd0;
         man_r    <= 23'h0;
      end else begin
         case (state)
            IDLE: begin
               if (available) begin
                  op_a  <= a;
                  op_b  <= b;
                  busy  <= 1'b1;
                  state <= UNPACK;
               end
            end

            UNPACK: begin
               sign  <= op_a[31] ^ op_b[31];
               ea    <= op_a[30:23];
               eb    <= op_b[30:23];
               mb    <= {1'b1, op_b[22:0]};
               rem   <= {2'b00, 1'b1, op_a[22:0]};
               q     <= 25'h0;
               iter  <= 5'h0;
               state <= DIVIDE;
            end

            DIVIDE: begin
               // After the subtraction rem_sub < mb < 2^24, so the shift
               // never loses a set bit.
               rem  <= {rem_sub[24:0], 1'b0};
               q    <= {q[23:0], qbit};
               iter <= iter + 5'd1;
               if (iter == 5'd24) begin
                  state <= NORMALIZE;
               end
            end

            NORMALIZE: begin
               exp_r <= exp_calc;
               man_r <= man_calc;
               state <= PACK;
            end

            PACK: begin
               quotient <= pack_result;
               done     <= 1'b1;
               state    <= DONE;
            end

            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_divider.sv
// -----------------------------------------------------------------------------
// tb_fp_divider
//   Self-checking bench for fp_divider. It applies a table of vectors with
//   reference quotients, then hand-written sequences: a reset in the middle
//   of an operation, and back-to-back operations with available held high.
// -----------------------------------------------------------------------------
module tb_fp_divider;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic        available;
   logic [31:0] quotient;
   logic        done;
   logic        busy;
   logic [2:0]  fsm_state;

   int          n_checks;
   int          n_pass;
   int          cycle;

   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] vq;
   } vec_t;

   vec_t vecs[20];

   fp_divider dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .available (available),
      .quotient  (quotient),
      .done      (done),
      .busy      (busy),
      .fsm_state (fsm_state)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // ---------------------------------------------------------------- checks
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Compare the quotient with the oldest entry in the scoreboard.
   task automatic score(input string name);
      logic [31:0] want;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: result %h with an empty expected queue", name, quotient);
      end else begin
         want = exp_q.pop_front();
         check(name, quotient, want);
      end
   endtask

   // Wait for done, sampled 1 time unit after each rising edge. Returns the
   // number of edges waited, or -1 if the budget runs out.
   task automatic wait_done(input int budget, output int edges);
      edges = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            edges = i;
            break;
         end
      end
   endtask

   // ---------------------------------------------------------------- driver
   // One complete operation. Drives at the falling edge, so the start edge
   // is the next rising edge. done must appear 28 edges later (29 cycles).
   task automatic run_op(input string name, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] vq);
      int edges;
      @(negedge clk);
      a         = va;
      b         = vb;
      available = 1'b1;
      exp_q.push_back(vq);
      @(posedge clk);
      #1;
      available = 1'b0;
      a         = $urandom();
      b         = $urandom();
      check({name, " busy_after_start"}, {31'h0, busy}, 32'd1);
      wait_done(60, edges);
      if (edges < 0) begin
         n_checks++;
         $display("FAIL %s timeout: no done within 60 cycles, expected after 28", name);
         void'(exp_q.pop_front());
      end else begin
         check({name, " latency"}, edges, 32'd28);
         score({name, " quotient"});
         @(posedge clk);
         #1;
         check({name, " done_width"}, {31'h0, done}, 32'd0);
         check({name, " busy_idle"}, {31'h0, busy}, 32'd0);
      end
   endtask

   // ---------------------------------------------------------------- test
   initial begin
      int edges;
      int last_done;
      int saw_done;
      vec_t bb[3];

      n_checks  = 0;
      n_pass    = 0;
      reset     = 1'b1;
      available = 1'b0;
      a         = 32'h0;
      b         = 32'h0;

      vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000}; // 6/2
      vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA}; // 1/3 truncated
      vecs[2]  = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000}; // -1/0
      vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000}; // 0/0
      vecs[4]  = '{32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000}; // 1/inf
      vecs[5]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000}; // overflow
      vecs[6]  = '{32'h0080_0000, 32'h4B00_0000, 32'h0000_0000}; // underflow
      vecs[7]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000}; // 1/1
      vecs[8]  = '{32'hC100_0000, 32'h4000_0000, 32'hC080_0000}; // -8/2
      vecs[9]  = '{32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAA}; // 2/3
      vecs[10] = '{32'h40E0_0000, 32'h4000_0000, 32'h4060_0000}; // 7/2
      vecs[11] = '{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000}; // inf/inf
      vecs[12] = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000}; // NaN/1
      vecs[13] = '{32'h3F80_0000, 32'hFF80_0001, 32'h7FC0_0000}; // 1/NaN
      vecs[14] = '{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000}; // inf/2
      vecs[15] = '{32'h8000_0000, 32'h40A0_0000, 32'h8000_0000}; // -0/5
      vecs[16] = '{32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000}; // 1/-inf
      vecs[17] = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000}; // denormal/1
      vecs[18] = '{32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000}; // inf/0
      vecs[19] = '{32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000}; // 1/-0

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset quotient", quotient, 32'h0);
      check("reset done", {31'h0, done}, 32'd0);
      check("reset busy", {31'h0, busy}, 32'd0);

      // Table-driven vectors
      for (int i = 0; i < 20; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vq);
      end

      // Reset ten cycles into a 6/2 operation: it must abort with no done
      @(negedge clk);
      a         = 32'h40C0_0000;
      b         = 32'h4000_0000;
      available = 1'b1;
      @(posedge clk);
      #1;
      available = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort quotient", quotient, 32'h0);
      check("abort busy", {31'h0, busy}, 32'd0);
      check("abort done", {31'h0, done}, 32'd0);
      saw_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1;
      end
      check("abort no_done", saw_done, 32'd0);
      run_op("after_abort", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);

      // Reset and available at the same edge: reset wins
      @(negedge clk);
      a         = 32'h40C0_0000;
      b         = 32'h4000_0000;
      available = 1'b1;
      reset     = 1'b1;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      available = 1'b0;
      check("reset_priority busy", {31'h0, busy}, 32'd0);

      // Back-to-back with available held high; operands change after each start
      bb[0] = vecs[0];
      bb[1] = vecs[1];
      bb[2] = vecs[10];
      @(negedge clk);
      a         = bb[0].va;
      b         = bb[0].vb;
      available = 1'b1;
      exp_q.push_back(bb[0].vq);
      @(posedge clk);
      #1;
      a = bb[1].va;
      b = bb[1].vb;
      last_done = 0;
      for (int i = 0; i < 3; i++) begin
         wait_done(60, edges);
         if (edges < 0) begin
            n_checks++;
            $display("FAIL b2b%0d timeout: no done within 60 cycles", i);
            break;
         end
         score($sformatf("b2b%0d quotient", i));
         if (i > 0) check($sformatf("b2b%0d spacing", i), cycle - last_done, 32'd30);
         last_done = cycle;
         if (i == 2) begin
            available = 1'b0;
         end else begin
            @(posedge clk);
            @(posedge clk);
            #1;
            exp_q.push_back(bb[i+1].vq);
            if (i == 0) begin
               a = bb[2].va;
               b = bb[2].vb;
            end else begin
               a = $urandom();
               b = $urandom();
            end
         end
      end
      repeat (3) @(posedge clk);
      #1;
      check("b2b stopped", {31'h0, busy}, 32'd0);
      check("scoreboard empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001: The block SHALL have no parameters; the format is fixed at IEEE-754 single precision.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: a  input  32  dividend (IEEE-754 single), sampled with available.
REQ-005: b  input  32  divisor (IEEE-754 single), sampled with available.
REQ-006: available  input  1  start request, sampled only in IDLE.
REQ-007: quotient  output  32  registered result a/b, held until next completion.
REQ-008: done  output  1  one-cycle pulse, quotient valid.
REQ-009: busy  output  1  high in every state except IDLE.

Function
REQ-010: The FSM SHALL have states IDLE, UNPACK, DIVIDE, NORMALIZE, PACK, DONE; transitions: IDLE->UNPACK on available=1, UNPACK->DIVIDE, DIVIDE->NORMALIZE after 25 iterations, NORMALIZE->PACK, PACK->DONE, DONE->IDLE.
REQ-011: At the IDLE->UNPACK edge, a and b SHALL be captured into internal registers; later changes on a/b SHALL be ignored.
REQ-012: available outside IDLE SHALL be ignored; no queueing; next start is accepted no earlier than the first IDLE cycle after done.
REQ-013: UNPACK SHALL extract sign, 8-bit exponents ea/eb, and 24-bit mantissas ma={1,a[22:0]}, mb={1,b[22:0]}; result sign = a[31] XOR b[31].
REQ-014: DIVIDE SHALL run a restoring division for exactly 25 cycles; remainder R (26 bits) starts at ma; each cycle: if R>=mb then qbit=1, R=R-mb, else qbit=0; then R=R<<1; qbits shift in MSB-first to form q[24:0].
REQ-015: NORMALIZE: if q[24]=1, mantissa=q[23:1] and e=ea-eb+127; else mantissa=q[22:0] and e=ea-eb+126; e computed as 10-bit signed.
REQ-016: Rounding SHALL be truncation (round toward zero); no guard/sticky bits.
REQ-017: Overflow e>=255 SHALL produce signed infinity {s,8'hFF,23'h0}; underflow e<=0 SHALL produce signed zero {s,31'h0}.
REQ-018: Operand classes: exponent 0 = zero (denormals flushed, mantissa ignored); exponent 255 with mantissa 0 = infinity; exponent 255 with mantissa !=0 = NaN.
REQ-019: Special cases override the arithmetic result in PACK, priority order: (1) a NaN, b NaN, 0/0, inf/inf -> 32'h7FC00000; (2) a inf or b zero -> signed infinity; (3) a zero or b inf -> signed zero.
REQ-020: Special cases SHALL NOT shorten latency; every operation takes the full path.
REQ-021: quotient SHALL update only at the PACK->DONE edge; done=1 exactly in the DONE cycle.
REQ-022: Latency: with available sampled at edge k, done SHALL be high in the cycle following edge k+28 (29 cycles start-to-done); busy high from edge k through the DONE cycle.
REQ-023: available held continuously high SHALL start a new operation at the first edge in IDLE after DONE, giving one operation per 30 cycles.

Reset
REQ-024: reset=1 at a rising edge SHALL force state IDLE, quotient=32'h0, done=0, busy=0, and clear internal operand, remainder and quotient registers.
REQ-025: reset mid-operation SHALL abort it with no done pulse; reset SHALL take priority over available at the same edge.
REQ-026: The first operation after reset release SHALL behave identically to any other.

Verification
REQ-027: a=32'h40C00000 (6.0), b=32'h40000000 (2.0) -> quotient=32'h40400000, done pulse exactly 29 cycles after start, width 1 cycle.
REQ-028: a=32'h3F800000 (1.0), b=32'h40400000 (3.0) -> quotient=32'h3EAAAAAA (truncated).
REQ-029: Specials: 32'hBF800000/32'h00000000 -> 32'hFF800000; 32'h00000000/32'h00000000 -> 32'h7FC00000; 32'h3F800000/32'h7F800000 -> 32'h00000000; all with 29-cycle latency.
REQ-030: Range: 32'h7F000000/32'h3E800000 -> 32'h7F800000 (overflow); 32'h00800000/32'h4B000000 -> 32'h00000000 (underflow).
REQ-031: Start 6.0/2.0, assert reset at cycle 10 for one cycle -> no done, quotient=0, busy=0; a new start of 1.0/3.0 then yields 32'h3EAAAAAA after 29 cycles.
REQ-032: available held high with operands changed mid-operation -> results match operands captured at each start; done pulses 30 cycles apart.
